// File: rtl/tsmem_pkg.sv
// rtl/tsmem_pkg.sv - shared constants and types for the timestamp memory arbiter
package tsmem_pkg;

    localparam int DVS_WIDTH_DEF  = 346;
    localparam int DVS_HEIGHT_DEF = 260;
    localparam int DEPTH          = DVS_WIDTH_DEF * DVS_HEIGHT_DEF;
    localparam int W_ADDR         = $clog2(DEPTH);

    typedef enum logic [1:0] {
        CLEAR,
        SERVE,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_ACT,
        OWN_HOST
    } owner_t;

endpackage

// File: rtl/tsmem_owner_pipe.sv
// rtl/tsmem_owner_pipe.sv - read-owner tag shift register and read-return demux
module tsmem_owner_pipe
    import tsmem_pkg::*;
#(
    parameter int WORD_SIZE = 18,
    parameter int READ_LAT  = 2
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           issue_tag,
    output logic                 busy,
    input  logic                 mem_rvld1,
    input  logic                 mem_rvld2,
    input  logic [WORD_SIZE-1:0] mem_rdata1,
    input  logic [WORD_SIZE-1:0] mem_rdata2,
    output logic                 act_rvld1,
    output logic                 act_rvld2,
    output logic [WORD_SIZE-1:0] act_rdata1,
    output logic [WORD_SIZE-1:0] act_rdata2,
    output logic                 host_rvld,
    output logic [WORD_SIZE-1:0] host_rdata
);

    owner_t in_tag;
    owner_t tail;
    owner_t tags [READ_LAT];

    // issue_tag describes the read on the memory bus this cycle, so the tail
    // lines up with the data READ_LAT cycles later
    assign in_tag = owner_t'(issue_tag);
    assign tail   = tags[READ_LAT-1];

    // Shift owner tags one stage per memory cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) tags[i] <= OWN_NONE;
        end else begin
            tags[0] <= in_tag;
            for (int i = 1; i < READ_LAT; i++) tags[i] <= tags[i-1];
        end
    end

    // Any read on the bus or in flight keeps the pipe busy
    always_comb begin
        busy = (in_tag != OWN_NONE);
        for (int i = 0; i < READ_LAT; i++) begin
            if (tags[i] != OWN_NONE) busy = 1'b1;
        end
    end

    // Route returning data to its owner; untagged returns are dropped
    always_comb begin
        act_rvld1  = 1'b0;
        act_rvld2  = 1'b0;
        act_rdata1 = '0;
        act_rdata2 = '0;
        host_rvld  = 1'b0;
        host_rdata = '0;
        case (tail)
            OWN_ACT: begin
                act_rvld1  = mem_rvld1;
                act_rvld2  = mem_rvld2;
                act_rdata1 = mem_rdata1;
                act_rdata2 = mem_rdata2;
            end
            OWN_HOST: begin
                host_rvld  = mem_rvld1;
                host_rdata = mem_rdata1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tsmem_arbiter.sv
// rtl/tsmem_arbiter.sv - timestamp memory clear sweep and act/host arbiter; host port enabled by TSMEM_HOST_EN
module tsmem_arbiter
    import tsmem_pkg::*;
#(
    parameter int DVS_WIDTH     = DVS_WIDTH_DEF,
    parameter int DVS_HEIGHT    = DVS_HEIGHT_DEF,
    parameter int WORD_SIZE     = 18,
    parameter int READ_LAT      = 2,
    parameter int HOST_MAX_WAIT = 15,
    localparam int DEPTH        = DVS_WIDTH * DVS_HEIGHT,
    localparam int W_ADDR       = $clog2(DEPTH)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req,
    output logic                 init_done,
    input  logic                 act_req,
    input  logic                 act_rw,
    input  logic [W_ADDR-1:0]    act_addr1,
    input  logic [W_ADDR-1:0]    act_addr2,
    input  logic [WORD_SIZE-1:0] act_wdata,
    output logic                 act_gnt,
    output logic                 act_rvld1,
    output logic                 act_rvld2,
    output logic [WORD_SIZE-1:0] act_rdata1,
    output logic [WORD_SIZE-1:0] act_rdata2,
    input  logic                 host_req,
    input  logic                 host_rw,
    input  logic [W_ADDR-1:0]    host_addr,
    input  logic [WORD_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvld,
    output logic [WORD_SIZE-1:0] host_rdata,
    output logic                 mem_cen,
    output logic                 mem_rw,
    output logic [W_ADDR-1:0]    mem_addr1,
    output logic [W_ADDR-1:0]    mem_addr2,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_rvld1,
    input  logic                 mem_rvld2,
    input  logic [WORD_SIZE-1:0] mem_rdata1,
    input  logic [WORD_SIZE-1:0] mem_rdata2
);

    localparam logic [W_ADDR-1:0] LAST_PTR = W_ADDR'(DEPTH - 2);
    localparam logic [W_ADDR-1:0] TOP_ADDR = W_ADDR'(DEPTH - 1);

    state_t                 state;
    logic [W_ADDR-1:0]      clr_ptr;
    logic                   host_win;
    logic                   pipe_busy;
    logic                   pipe_host_rvld;
    logic [WORD_SIZE-1:0]   pipe_host_rdata;
    owner_t                 issue_tag;

`ifdef TSMEM_HOST_EN
    localparam int W_STARVE = $clog2(HOST_MAX_WAIT + 2);

    logic [W_STARVE-1:0]    starve_cnt;
    logic                   host_pend;
    logic                   host_force;

    // host_gnt high means the held request is the one just served
    assign host_pend  = host_req && !host_gnt;
    assign host_force = host_pend && (starve_cnt == W_STARVE'(HOST_MAX_WAIT));
    assign host_win   = host_pend && (!act_req || host_force);

    // Count cycles a pending host request loses to the activation engine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == SERVE && !clear_req) begin
            if (host_win)
                starve_cnt <= '0;
            else if (host_pend && act_req)
                starve_cnt <= starve_cnt + W_STARVE'(1);
        end
    end

    assign host_rvld  = pipe_host_rvld;
    assign host_rdata = pipe_host_rdata;
`else
    logic unused_host;

    assign host_win    = 1'b0;
    assign host_rvld   = 1'b0;
    assign host_rdata  = '0;
    assign unused_host = ^{host_req, host_rw, host_addr, host_wdata, pipe_host_rvld, pipe_host_rdata};
`endif

    // Only reads currently on the bus get an owner tag
    assign issue_tag = (act_gnt && mem_rw)  ? OWN_ACT  :
                       (host_gnt && mem_rw) ? OWN_HOST : OWN_NONE;

    // Clear sweep, grant selection and registered memory bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            init_done <= 1'b0;
            mem_cen   <= 1'b1;
            mem_rw    <= 1'b1;
            mem_addr1 <= '0;
            mem_addr2 <= '0;
            mem_wdata <= '0;
            act_gnt   <= 1'b0;
            host_gnt  <= 1'b0;
        end else begin
            act_gnt  <= 1'b0;
            host_gnt <= 1'b0;
            mem_cen  <= 1'b1;
            case (state)
                CLEAR: begin
                    mem_cen   <= 1'b0;
                    mem_rw    <= 1'b0;
                    mem_wdata <= '0;
                    mem_addr1 <= clr_ptr;
                    mem_addr2 <= (clr_ptr == TOP_ADDR) ? TOP_ADDR : clr_ptr + W_ADDR'(1);
                    if (clr_ptr >= LAST_PTR) begin
                        state     <= SERVE;
                        init_done <= 1'b1;
                        clr_ptr   <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + W_ADDR'(2);
                    end
                end
                SERVE: begin
                    if (clear_req) begin
                        state <= DRAIN;
                    end else if (host_win) begin
                        host_gnt  <= 1'b1;
                        mem_cen   <= 1'b0;
                        mem_rw    <= host_rw;
                        mem_addr1 <= host_addr;
                        mem_wdata <= host_wdata;
                    end else if (act_req) begin
                        act_gnt   <= 1'b1;
                        mem_cen   <= 1'b0;
                        mem_rw    <= act_rw;
                        mem_addr1 <= act_addr1;
                        mem_addr2 <= act_addr2;
                        mem_wdata <= act_wdata;
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state     <= CLEAR;
                        clr_ptr   <= '0;
                        init_done <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    tsmem_owner_pipe #(
        .WORD_SIZE (WORD_SIZE),
        .READ_LAT  (READ_LAT)
    ) u_owner_pipe (
        .clk        (clk),
        .rst        (rst),
        .issue_tag  (issue_tag),
        .busy       (pipe_busy),
        .mem_rvld1  (mem_rvld1),
        .mem_rvld2  (mem_rvld2),
        .mem_rdata1 (mem_rdata1),
        .mem_rdata2 (mem_rdata2),
        .act_rvld1  (act_rvld1),
        .act_rvld2  (act_rvld2),
        .act_rdata1 (act_rdata1),
        .act_rdata2 (act_rdata2),
        .host_rvld  (pipe_host_rvld),
        .host_rdata (pipe_host_rdata)
    );

endmodule

// File: tb/tb_tsmem_arbiter.sv
// tb/tb_tsmem_arbiter.sv - directed bench for tsmem_arbiter with an 8-word memory
module tb_tsmem_arbiter;

    localparam int WS = 18;
    localparam int WA = 3;
`ifdef TSMEM_HOST_EN
    localparam bit HOST_ON = 1'b1;
`else
    localparam bit HOST_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_req = 1'b0;
    logic          init_done;
    logic          act_req = 1'b0;
    logic          act_rw = 1'b1;
    logic [WA-1:0] act_addr1 = '0;
    logic [WA-1:0] act_addr2 = '0;
    logic [WS-1:0] act_wdata = '0;
    logic          act_gnt, act_rvld1, act_rvld2;
    logic [WS-1:0] act_rdata1, act_rdata2;
    logic          host_req = 1'b0;
    logic          host_rw = 1'b1;
    logic [WA-1:0] host_addr = '0;
    logic [WS-1:0] host_wdata = '0;
    logic          host_gnt, host_rvld;
    logic [WS-1:0] host_rdata;
    logic          mem_cen, mem_rw;
    logic [WA-1:0] mem_addr1, mem_addr2;
    logic [WS-1:0] mem_wdata;
    logic          mem_rvld1, mem_rvld2;
    logic [WS-1:0] mem_rdata1, mem_rdata2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tsmem_arbiter #(
        .DVS_WIDTH     (4),
        .DVS_HEIGHT    (2),
        .WORD_SIZE     (WS),
        .READ_LAT      (2),
        .HOST_MAX_WAIT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .init_done  (init_done),
        .act_req    (act_req),
        .act_rw     (act_rw),
        .act_addr1  (act_addr1),
        .act_addr2  (act_addr2),
        .act_wdata  (act_wdata),
        .act_gnt    (act_gnt),
        .act_rvld1  (act_rvld1),
        .act_rvld2  (act_rvld2),
        .act_rdata1 (act_rdata1),
        .act_rdata2 (act_rdata2),
        .host_req   (host_req),
        .host_rw    (host_rw),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvld  (host_rvld),
        .host_rdata (host_rdata),
        .mem_cen    (mem_cen),
        .mem_rw     (mem_rw),
        .mem_addr1  (mem_addr1),
        .mem_addr2  (mem_addr2),
        .mem_wdata  (mem_wdata),
        .mem_rvld1  (mem_rvld1),
        .mem_rvld2  (mem_rvld2),
        .mem_rdata1 (mem_rdata1),
        .mem_rdata2 (mem_rdata2)
    );

    // SRAM stand-in: fixed read contents, two-cycle read latency
    logic [WS-1:0] rom [8] = '{18'h011, 18'h022, 18'h033, 18'h0A3,
                               18'h044, 18'h155, 18'h2AA, 18'h077};
    logic          s0_v, s1_v;
    logic [WA-1:0] s0_a1, s0_a2, s1_a1, s1_a2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_v <= 1'b0; s1_v <= 1'b0;
            s0_a1 <= '0; s0_a2 <= '0; s1_a1 <= '0; s1_a2 <= '0;
        end else begin
            s0_v  <= !mem_cen && mem_rw;
            s0_a1 <= mem_addr1;
            s0_a2 <= mem_addr2;
            s1_v  <= s0_v;
            s1_a1 <= s0_a1;
            s1_a2 <= s0_a2;
        end
    end

    assign mem_rvld1  = s1_v;
    assign mem_rvld2  = s1_v;
    assign mem_rdata1 = s1_v ? rom[s1_a1] : '0;
    assign mem_rdata2 = s1_v ? rom[s1_a2] : '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acts;
        bit got_host, saw_low, act_seen, got_first;
        logic [31:0] first_a1, first_a2;

        first_a1 = '1;
        first_a2 = '1;
        #12;
        check("rst_init_done", init_done, 0);
        check("rst_mem_cen", mem_cen, 1);
        check("rst_mem_rw", mem_rw, 1);
        check("rst_addr1", mem_addr1, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_act_gnt", act_gnt, 0);
        check("rst_host_gnt", host_gnt, 0);
        check("rst_act_rvld1", act_rvld1, 0);
        rst = 1'b0;

        // 1: clear sweep of pairs (0,1)..(6,7)
        for (int i = 0; i < 4; i++) begin
            tick();
            check("clr_cen", mem_cen, 0);
            check("clr_rw", mem_rw, 0);
            check("clr_addr1", mem_addr1, 2 * i);
            check("clr_addr2", mem_addr2, 2 * i + 1);
            check("clr_wdata", mem_wdata, 0);
            if (i < 3) check("clr_init_low", init_done, 0);
        end
        tick();
        check("init_done", init_done, 1);
        check("idle_cen", mem_cen, 1);

        // 2: single activation read, data returns two cycles after issue
        act_req = 1'b1; act_rw = 1'b1; act_addr1 = 3'd5; act_addr2 = 3'd6;
        tick();
        check("rd_act_gnt", act_gnt, 1);
        check("rd_cen", mem_cen, 0);
        check("rd_rw", mem_rw, 1);
        check("rd_addr1", mem_addr1, 5);
        check("rd_addr2", mem_addr2, 6);
        act_req = 1'b0;
        tick();
        check("rd_gnt_pulse", act_gnt, 0);
        check("rd_rvld_early", act_rvld1, 0);
        tick();
        check("rd_rvld1", act_rvld1, 1);
        check("rd_rvld2", act_rvld2, 1);
        check("rd_rdata1", act_rdata1, 18'h155);
        check("rd_rdata2", act_rdata2, 18'h2AA);
        check("rd_host_quiet", host_rvld, 0);
        tick();

        // 3: host starved by a continuous activation stream
        act_req = 1'b1; act_addr1 = 3'd1; act_addr2 = 3'd2;
        host_req = 1'b1; host_rw = 1'b1; host_addr = 3'd3;
        acts = 0;
        got_host = 1'b0;
        for (int i = 0; i < 30 && !got_host; i++) begin
            tick();
            if (host_gnt) begin
                got_host = 1'b1;
                check("starve_act_blocked", act_gnt, 0);
                check("starve_host_addr", mem_addr1, 3);
            end else if (act_gnt) begin
                acts++;
            end
        end
        check("starve_host_gnt", got_host, HOST_ON);
        check("starve_act_grants", acts, HOST_ON ? 15 : 30);
        act_req = 1'b0; host_req = 1'b0;
        tick();
        check("starve_prev_act_rvld", act_rvld1, 1);
        check("starve_host_early", host_rvld, 0);
        tick();
        check("starve_host_rvld", host_rvld, HOST_ON);
        check("starve_host_rdata", host_rdata, HOST_ON ? 18'h0A3 : 18'h0);
        check("starve_act_quiet", act_rvld1, !HOST_ON);
        tick();
        tick();

        // 4: back-to-back act then host reads keep their owners
        act_req = 1'b1; act_addr1 = 3'd1; act_addr2 = 3'd2;
        host_req = 1'b1; host_addr = 3'd4;
        tick();
        check("b2b_act_gnt", act_gnt, 1);
        check("b2b_host_wait", host_gnt, 0);
        act_req = 1'b0;
        tick();
        check("b2b_host_gnt", host_gnt, HOST_ON);
        check("b2b_addr2_held", mem_addr2, 2);
        host_req = 1'b0;
        tick();
        check("b2b_act_rvld", act_rvld1, 1);
        check("b2b_act_rdata1", act_rdata1, 18'h022);
        check("b2b_act_rdata2", act_rdata2, 18'h033);
        check("b2b_host_not_yet", host_rvld, 0);
        tick();
        check("b2b_host_rvld", host_rvld, HOST_ON);
        check("b2b_host_rdata", host_rdata, HOST_ON ? 18'h044 : 18'h0);
        check("b2b_act_quiet", act_rvld1, 0);
        tick();

        // 5: re-clear with a read in flight
        act_req = 1'b1; act_addr1 = 3'd5; act_addr2 = 3'd6;
        tick();
        check("drain_issue_gnt", act_gnt, 1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("drain_no_gnt", act_gnt, 0);
        tick();
        check("drain_rvld", act_rvld1, 1);
        check("drain_rdata1", act_rdata1, 18'h155);
        saw_low = 1'b0; act_seen = 1'b0; got_first = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (act_gnt) act_seen = 1'b1;
            if (!init_done) saw_low = 1'b1;
            if (!got_first && !mem_cen && !mem_rw) begin
                got_first = 1'b1;
                first_a1 = 32'(mem_addr1);
                first_a2 = 32'(mem_addr2);
            end
            if (saw_low && init_done) break;
        end
        check("reclr_init_low", saw_low, 1);
        check("reclr_init_done", init_done, 1);
        check("reclr_no_act_gnt", act_seen, 0);
        check("reclr_first_a1", first_a1, 0);
        check("reclr_first_a2", first_a2, 1);
        tick();
        check("post_clear_gnt", act_gnt, 1);
        act_req = 1'b0;
        tick();
        tick();
        tick();

        // 6: reset in the middle of a clear sweep
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        got_first = 1'b0;
        for (int i = 0; i < 12 && !got_first; i++) begin
            tick();
            if (!mem_cen && !mem_rw && mem_addr1 == 3'd2) got_first = 1'b1;
        end
        check("mid_clear_reached", got_first, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_init_done", init_done, 0);
        check("mid_rst_cen", mem_cen, 1);
        check("mid_rst_rw", mem_rw, 1);
        check("mid_rst_addr1", mem_addr1, 0);
        check("mid_rst_addr2", mem_addr2, 0);
        #2 rst = 1'b0;
        tick();
        check("restart_cen", mem_cen, 0);
        check("restart_addr1", mem_addr1, 0);
        check("restart_addr2", mem_addr2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
